// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-mux select
// encodings and the helper that resolves forwarding priority.
package hazard_forward_unit_pkg;

    // Width of the EX operand three-to-one mux selects
    localparam int unsigned FWD_SEL_W = 2;

    // Operand-mux select encodings; the datapath muxes decode the same values.
    // 2'd3 is deliberately left unused.
    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_REGFILE = 2'd0,
        FWD_EXMEM   = 2'd1,
        FWD_MEMWB   = 2'd2
    } fwd_sel_e;

    // Write-back control bits carried alongside a destination register
    typedef struct packed {
        logic rw;
        logic mr;
    } wr_ctl_t;

    // Younger producer (EX/MEM) takes priority over the older one (MEM/WB)
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_REGFILE;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// Per-stage pipeline register: synchronous active-high reset, and a bubble
// input that loads all-zero (invalid, no write, no load) instead of d.
module hazard_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Stage contents: cleared by reset, zeroed by a bubble, otherwise advance
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding unit for a five-stage pipeline.
// Tracks EX, MEM and WB shadows of the instruction stream, drives the EX
// operand-mux selects from registered state only, and raises a one-cycle
// load-use stall. Optional stall performance counter: define
// HAZARD_PERF_CNT_EN to add the counter and the stall_count port.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic [REG_W-1:0]     id_dest,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 flush,
    output logic [FWD_SEL_W-1:0] fwd_a_sel,
    output logic [FWD_SEL_W-1:0] fwd_b_sel,
    output logic                 stall
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_count
`endif
);

    // Packed stage layouts: EX {valid, rs, rt, dest, ctl}, MEM {dest, ctl}, WB {dest, rw}
    localparam int unsigned CTL_W = $bits(wr_ctl_t);
    localparam int unsigned EX_W  = 1 + 3 * REG_W + CTL_W;
    localparam int unsigned MEM_W = REG_W + CTL_W;
    localparam int unsigned WB_W  = REG_W + 1;

    logic [EX_W-1:0]  ex_d;
    logic [EX_W-1:0]  ex_q;
    logic [MEM_W-1:0] mem_d;
    logic [MEM_W-1:0] mem_q;
    logic [WB_W-1:0]  wb_d;
    logic [WB_W-1:0]  wb_q;
    logic             ex_bubble;

    logic             ex_valid;
    logic [REG_W-1:0] ex_rs;
    logic [REG_W-1:0] ex_rt;
    logic [REG_W-1:0] ex_dest;
    wr_ctl_t          ex_ctl;
    logic [REG_W-1:0] mem_dest;
    wr_ctl_t          mem_ctl;
    logic [REG_W-1:0] wb_dest;
    logic             wb_rw;

    logic             mem_hit_a;
    logic             mem_hit_b;
    logic             wb_hit_a;
    logic             wb_hit_b;
    logic             load_use;

    // Load flag in MEM is tracked for completeness but nothing downstream needs it
    logic             unused_mem_mr;

    // Field views of the stage registers
    assign {ex_valid, ex_rs, ex_rt, ex_dest, ex_ctl} = ex_q;
    assign {mem_dest, mem_ctl}                       = mem_q;
    assign {wb_dest, wb_rw}                          = wb_q;
    assign unused_mem_mr                             = mem_ctl.mr;

    // Next-state payloads: EX takes the ID instruction, MEM takes EX, WB takes MEM
    always_comb begin
        ex_d      = {id_valid, id_rs, id_rt, id_dest, id_reg_write, id_mem_read};
        mem_d     = {ex_dest, ex_ctl};
        wb_d      = {mem_dest, mem_ctl.rw};
        // Stall, flush and an invalid ID slot all put a bubble into EX
        ex_bubble = stall | flush | ~id_valid;
    end

    hazard_stage_reg #(
        .W (EX_W)
    ) u_ex_stage (
        .clk    (clk),
        .rst    (rst),
        .bubble (ex_bubble),
        .d      (ex_d),
        .q      (ex_q)
    );

    // MEM and WB advance every cycle, including stall and flush cycles
    hazard_stage_reg #(
        .W (MEM_W)
    ) u_mem_stage (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (mem_d),
        .q      (mem_q)
    );

    hazard_stage_reg #(
        .W (WB_W)
    ) u_wb_stage (
        .clk    (clk),
        .rst    (rst),
        .bubble (1'b0),
        .d      (wb_d),
        .q      (wb_q)
    );

    // Producer matches against the EX sources; register 0 never forwards
    always_comb begin
        mem_hit_a = mem_ctl.rw && (mem_dest != '0) && (mem_dest == ex_rs);
        mem_hit_b = mem_ctl.rw && (mem_dest != '0) && (mem_dest == ex_rt);
        wb_hit_a  = wb_rw && (wb_dest != '0) && (wb_dest == ex_rs);
        wb_hit_b  = wb_rw && (wb_dest != '0) && (wb_dest == ex_rt);
    end

    // Operand selects from registered state only; an empty EX reads the register file
    always_comb begin
        fwd_a_sel = FWD_REGFILE;
        fwd_b_sel = FWD_REGFILE;
        if (ex_valid) begin
            fwd_a_sel = fwd_pick(mem_hit_a, wb_hit_a);
            fwd_b_sel = fwd_pick(mem_hit_b, wb_hit_b);
        end
    end

    // Load-use hazard: a load in EX feeding a source of the ID instruction;
    // a flush squashes the consumer, so it takes precedence over the stall
    always_comb begin
        load_use = id_valid && ex_valid && ex_ctl.mr && (ex_dest != '0) &&
                   ((ex_dest == id_rs) || (ex_dest == id_rt));
        stall    = load_use && !flush;
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed vector table for the
// named pipeline scenarios, then randomized traffic against a reference model.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_W (5),
        .CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    // Reference model: in-flight instructions by age, 0 = EX, 1 = MEM, 2 = WB
    bit m_v[3];
    int m_rs[3];
    int m_rt[3];
    int m_d[3];
    bit m_rw[3];
    bit m_mr[3];
    int m_cnt   = 0;
    bit primed  = 1'b0;

    // Nearest older instruction that writes src; its age is the select code
    function automatic logic [1:0] model_fwd(input int src);
        if (!m_v[0]) return 2'd0;
        for (int k = 1; k <= 2; k++) begin
            if (m_rw[k] && m_d[k] != 0 && m_d[k] == src) return 2'(k);
        end
        return 2'd0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of ID inputs, produce the model's expectation, advance the model
    task automatic do_cycle(input bit r, input bit v, input int rs, input int rt,
                            input int d, input bit rw, input bit mr, input bit fl,
                            output bit e_stall, output logic [1:0] e_a,
                            output logic [1:0] e_b);
        @(negedge clk);
        rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_dest = 5'(d);
        id_reg_write = rw; id_mem_read = mr; flush = fl;
        #1;
        e_a     = model_fwd(m_rs[0]);
        e_b     = model_fwd(m_rt[0]);
        e_stall = v && m_v[0] && m_mr[0] && m_d[0] != 0 &&
                  (m_d[0] == rs || m_d[0] == rt) && !fl;
`ifdef HAZARD_PERF_CNT_EN
        if (primed) check("stall_count", int'(stall_count), m_cnt);
`endif
        if (r) begin
            for (int k = 0; k < 3; k++) begin
                m_v[k] = 0; m_rs[k] = 0; m_rt[k] = 0; m_d[k] = 0; m_rw[k] = 0; m_mr[k] = 0;
            end
            m_cnt  = 0;
            primed = 1'b1;
        end else begin
            if (e_stall && m_cnt < 15) m_cnt++;
            for (int k = 2; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_rs[k] = m_rs[k-1]; m_rt[k] = m_rt[k-1];
                m_d[k] = m_d[k-1]; m_rw[k] = m_rw[k-1]; m_mr[k] = m_mr[k-1];
            end
            if (v && !e_stall && !fl) begin
                m_v[0] = 1; m_rs[0] = rs; m_rt[0] = rt; m_d[0] = d; m_rw[0] = rw; m_mr[0] = mr;
            end else begin
                m_v[0] = 0; m_rs[0] = 0; m_rt[0] = 0; m_d[0] = 0; m_rw[0] = 0; m_mr[0] = 0;
            end
        end
    endtask

    typedef struct packed {
        logic       chk;
        logic       r;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] d;
        logic       rw;
        logic       mr;
        logic       fl;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
    } vec_t;

    function automatic vec_t mk(input bit chk, input bit r, input bit v, input int rs,
                                input int rt, input int d, input bit rw, input bit mr,
                                input bit fl, input int ea, input int eb, input bit es);
        vec_t t;
        t.chk = chk; t.r = r; t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.d = 5'(d);
        t.rw = rw; t.mr = mr; t.fl = fl; t.ea = 2'(ea); t.eb = 2'(eb); t.es = es;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        bit         es;
        logic [1:0] ea;
        logic [1:0] eb;
        bit         r, v, rw, mr, fl;
        int         rs, rt, d;

        rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_dest = 0;
        id_reg_write = 0; id_mem_read = 0; flush = 0;

        // Reset, then the quiescent post-reset outputs
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, es, ea, eb);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, es, ea, eb);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, es, ea, eb);
        check("reset_fwd_a", int'(fwd_a_sel), 0);
        check("reset_fwd_b", int'(fwd_b_sel), 0);
        check("reset_stall", int'(stall), 0);

        // Directed scenarios: {chk, rst, valid, rs, rt, dest, rw, mr, flush, exp_a, exp_b, exp_stall}
        // back-to-back ALU: add $3; sub $4,$3,$5
        tbl.push_back(mk(1, 0, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 5, 4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // gap of one: add $3; nop; or $6,$3,$3
        tbl.push_back(mk(1, 0, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 3, 6, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // double match: add $3; add $3; sub $7,$3,$1 -> younger wins
        tbl.push_back(mk(1, 0, 1, 1, 2, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 4, 5, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // load-use: lw $8; add $9,$8,$2 (held during the stall)
        tbl.push_back(mk(1, 0, 1, 29, 0, 8, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8, 2, 9, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8, 2, 9, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // register 0: add $0; add $1,$0,$0; lw $0; add $5,$0,$0
        tbl.push_back(mk(1, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // flush with load-use in the same cycle: no stall, EX gets a bubble
        tbl.push_back(mk(1, 0, 1, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 8, 8, 9, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // reset during a stall: stall drops, the load is discarded
        tbl.push_back(mk(1, 0, 1, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8, 2, 9, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 8, 2, 9, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            do_cycle(tbl[i].r, tbl[i].v, int'(tbl[i].rs), int'(tbl[i].rt), int'(tbl[i].d),
                     tbl[i].rw, tbl[i].mr, tbl[i].fl, es, ea, eb);
            if (tbl[i].chk) begin
                check($sformatf("row%0d_fwd_a", i), int'(fwd_a_sel), int'(tbl[i].ea));
                check($sformatf("row%0d_fwd_b", i), int'(fwd_b_sel), int'(tbl[i].eb));
                check($sformatf("row%0d_stall", i), int'(stall), int'(tbl[i].es));
            end
        end

        // Randomized traffic on a small register set; upstream holds ID while stalled
        es = 0; r = 0; v = 0; rs = 0; rt = 0; d = 0; rw = 0; mr = 0; fl = 0;
        for (int n = 0; n < 1500; n++) begin
            if (!es || r) begin
                v  = ($urandom_range(0, 99) < 85);
                rs = $urandom_range(0, 3);
                rt = $urandom_range(0, 3);
                d  = $urandom_range(0, 3);
                rw = ($urandom_range(0, 3) != 0);
                mr = rw && ($urandom_range(0, 2) == 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 199) == 0);
            do_cycle(r, v, rs, rt, d, rw, mr, fl, es, ea, eb);
            check("rand_fwd_a", int'(fwd_a_sel), int'(ea));
            check("rand_fwd_b", int'(fwd_b_sel), int'(eb));
            check("rand_stall", int'(stall), int'(es));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
